// File: rtl/gemm_pkg.sv
// Shared encodings and types for the GEMM issue unit: func3 opcodes and the run-state enum.
package gemm_pkg;

  localparam int unsigned DIM_W_DEF = 10;

  localparam logic [2:0] GEMM_SETA   = 3'b000;
  localparam logic [2:0] GEMM_SETB   = 3'b001;
  localparam logic [2:0] GEMM_SETC   = 3'b010;
  localparam logic [2:0] GEMM_SETDIM = 3'b011;
  localparam logic [2:0] GEMM_START  = 3'b100;
  localparam logic [2:0] GEMM_WAIT   = 3'b101;

  typedef enum logic {
    StIdle,
    StRun
  } gemm_state_e;

  // 110 and 111 are the only illegal encodings.
  function automatic logic gemm_func3_legal(input logic [2:0] func3);
    return !(func3[2] && func3[1]);
  endfunction

endpackage

// File: rtl/gemm_cfg_regs.sv
// Accelerator configuration registers: three base addresses and the M/K/N dimensions.
module gemm_cfg_regs
  import gemm_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DIM_W  = DIM_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              freeze_i,
  input  logic              we_a_i,
  input  logic              we_b_i,
  input  logic              we_c_i,
  input  logic              we_dim_i,
  input  logic [31:0]       rs1_i,
  input  logic [DIM_W-1:0]  rs2_lo_i,
  output logic [ADDR_W-1:0] base_a_o,
  output logic [ADDR_W-1:0] base_b_o,
  output logic [ADDR_W-1:0] base_c_o,
  output logic [DIM_W-1:0]  dim_m_o,
  output logic [DIM_W-1:0]  dim_k_o,
  output logic [DIM_W-1:0]  dim_n_o
);

  logic [ADDR_W-1:0] base_a_q, base_b_q, base_c_q;
  logic [DIM_W-1:0]  dim_m_q, dim_k_q, dim_n_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_a_q <= '0;
      base_b_q <= '0;
      base_c_q <= '0;
      dim_m_q  <= '0;
      dim_k_q  <= '0;
      dim_n_q  <= '0;
    end else if (!freeze_i) begin
      if (we_a_i) base_a_q <= rs1_i[ADDR_W-1:0];
      if (we_b_i) base_b_q <= rs1_i[ADDR_W-1:0];
      if (we_c_i) base_c_q <= rs1_i[ADDR_W-1:0];
      if (we_dim_i) begin
        dim_m_q <= rs1_i[DIM_W-1:0];
        dim_k_q <= rs1_i[DIM_W+15:16];
        dim_n_q <= rs2_lo_i;
      end
    end
  end

  assign base_a_o = base_a_q;
  assign base_b_o = base_b_q;
  assign base_c_o = base_c_q;
  assign dim_m_o  = dim_m_q;
  assign dim_k_o  = dim_k_q;
  assign dim_n_o  = dim_n_q;

endmodule

// File: rtl/gemm_issue_unit.sv
// EX-stage GEMM issue: decodes config writes, launches runs, stalls conflicting
// instructions while a run is in flight and counts run cycles.
module gemm_issue_unit
  import gemm_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DIM_W  = DIM_W_DEF,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              is_gemm_i,
  input  logic [2:0]        func3_i,
  input  logic [31:0]       rs1_data_i,
  input  logic [31:0]       rs2_data_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              gemm_done_i,
  output logic              stall_o,
  output logic              gemm_start_o,
  output logic [ADDR_W-1:0] base_a_o,
  output logic [ADDR_W-1:0] base_b_o,
  output logic [ADDR_W-1:0] base_c_o,
  output logic [DIM_W-1:0]  dim_m_o,
  output logic [DIM_W-1:0]  dim_k_o,
  output logic [DIM_W-1:0]  dim_n_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  perf_cycles_o
);

  gemm_state_e      state_q, state_d;
  logic             start_q, start_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc, dims_ok, in_run;

  logic unused_rs2;
  assign unused_rs2 = ^rs2_data_i[31:DIM_W];

  assign in_run = (state_q == StRun);

  // Stall depends only on registered state, so it stays high through the done
  // cycle and the held instruction is accepted the cycle after.
  assign stall_o = in_run & is_gemm_i & ~flush_i & gemm_func3_legal(func3_i);
  assign acc     = is_gemm_i & ~flush_i & ~stall_i & ~stall_o;
  assign dims_ok = (|dim_m_o) & (|dim_k_o) & (|dim_n_o);

  gemm_cfg_regs #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W)
  ) u_cfg_regs (
    .clk_i    (clk),
    .rst_i    (rst),
    .freeze_i (in_run),
    .we_a_i   (acc && func3_i == GEMM_SETA),
    .we_b_i   (acc && func3_i == GEMM_SETB),
    .we_c_i   (acc && func3_i == GEMM_SETC),
    .we_dim_i (acc && func3_i == GEMM_SETDIM),
    .rs1_i    (rs1_data_i),
    .rs2_lo_i (rs2_data_i[DIM_W-1:0]),
    .base_a_o (base_a_o),
    .base_b_o (base_b_o),
    .base_c_o (base_c_o),
    .dim_m_o  (dim_m_o),
    .dim_k_o  (dim_k_o),
    .dim_n_o  (dim_n_o)
  );

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (acc && !gemm_func3_legal(func3_i)) err_d = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (acc && func3_i == GEMM_START) begin
          if (dims_ok) begin
            state_d = StRun;
            start_d = 1'b1;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        if (gemm_done_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gemm_start_o  = start_q;
  assign busy_o        = in_run;
  assign err_o         = err_q;
  assign perf_cycles_o = cnt_q;

endmodule

// File: tb/tb_gemm_issue_unit.sv
// Directed bench for gemm_issue_unit: vector table for single-cycle decode, hand
// sequences for runs, stalls, done timing and reset.
module tb_gemm_issue_unit;
  import gemm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_gemm, flush, stall_in, done;
  logic [2:0]  func3;
  logic [31:0] rs1, rs2;
  logic        stall_o, gemm_start_o, busy_o, err_o;
  logic [31:0] base_a_o, base_b_o, base_c_o, perf_cycles_o;
  logic [9:0]  dim_m_o, dim_k_o, dim_n_o;

  int tests  = 0;
  int errors = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  gemm_issue_unit dut (
    .clk           (clk),
    .rst           (rst),
    .is_gemm_i     (is_gemm),
    .func3_i       (func3),
    .rs1_data_i    (rs1),
    .rs2_data_i    (rs2),
    .flush_i       (flush),
    .stall_i       (stall_in),
    .gemm_done_i   (done),
    .stall_o       (stall_o),
    .gemm_start_o  (gemm_start_o),
    .base_a_o      (base_a_o),
    .base_b_o      (base_b_o),
    .base_c_o      (base_c_o),
    .dim_m_o       (dim_m_o),
    .dim_k_o       (dim_k_o),
    .dim_n_o       (dim_n_o),
    .busy_o        (busy_o),
    .err_o         (err_o),
    .perf_cycles_o (perf_cycles_o)
  );

  always @(negedge clk) if (gemm_start_o) pulses++;

  typedef struct {
    string       name;
    logic        ig;
    logic [2:0]  f3;
    logic [31:0] r1, r2;
    logic        fl, st, dn;
    logic        e_stall, e_start, e_busy, e_err;
    logic [31:0] e_a, e_b, e_c;
    logic [9:0]  e_m, e_k, e_n;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic ig, input logic [2:0] f3, input logic [31:0] r1, input logic [31:0] r2,
                     input logic fl, input logic st, input logic dn, output logic stall_s);
    @(negedge clk);
    is_gemm = ig; func3 = f3; rs1 = r1; rs2 = r2; flush = fl; stall_in = st; done = dn;
    #1 stall_s = stall_o;
    @(posedge clk);
    #1;
  endtask

  task automatic run_rows(input int lo, input int hi);
    logic s;
    for (int i = lo; i < hi; i++) begin
      cyc(vecs[i].ig, vecs[i].f3, vecs[i].r1, vecs[i].r2, vecs[i].fl, vecs[i].st, vecs[i].dn, s);
      chk({vecs[i].name, " stall"}, 32'(s), 32'(vecs[i].e_stall));
      chk({vecs[i].name, " start"}, 32'(gemm_start_o), 32'(vecs[i].e_start));
      chk({vecs[i].name, " busy"}, 32'(busy_o), 32'(vecs[i].e_busy));
      chk({vecs[i].name, " err"}, 32'(err_o), 32'(vecs[i].e_err));
      chk({vecs[i].name, " base_a"}, base_a_o, vecs[i].e_a);
      chk({vecs[i].name, " base_b"}, base_b_o, vecs[i].e_b);
      chk({vecs[i].name, " base_c"}, base_c_o, vecs[i].e_c);
      chk({vecs[i].name, " dim_m"}, 32'(dim_m_o), 32'(vecs[i].e_m));
      chk({vecs[i].name, " dim_k"}, 32'(dim_k_o), 32'(vecs[i].e_k));
      chk({vecs[i].name, " dim_n"}, 32'(dim_n_o), 32'(vecs[i].e_n));
    end
  endtask

  initial begin
    logic s;
    int   p0;

    // name, ig, f3, rs1, rs2, fl, st, dn, stall, start, busy, err, a, b, c, m, k, n
    vecs[0]  = '{"seta", 1, GEMM_SETA, 32'h1000, 0, 0, 0, 0, 0, 0, 0, 0,
                 32'h1000, 0, 0, 0, 0, 0};
    vecs[1]  = '{"setb", 1, GEMM_SETB, 32'h2000, 0, 0, 0, 0, 0, 0, 0, 0,
                 32'h1000, 32'h2000, 0, 0, 0, 0};
    vecs[2]  = '{"setc", 1, GEMM_SETC, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0,
                 32'h1000, 32'h2000, 32'h3000, 0, 0, 0};
    vecs[3]  = '{"setdim", 1, GEMM_SETDIM, 32'h0004_0008, 32'h10, 0, 0, 0, 0, 0, 0, 0,
                 32'h1000, 32'h2000, 32'h3000, 8, 4, 16};
    vecs[4]  = '{"wait_idle", 1, GEMM_WAIT, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 32'h1000, 32'h2000, 32'h3000, 8, 4, 16};
    vecs[5]  = '{"seta_flush", 1, GEMM_SETA, 32'hBEEF, 0, 1, 0, 0, 0, 0, 0, 0,
                 32'h1000, 32'h2000, 32'h3000, 8, 4, 16};
    vecs[6]  = '{"seta_stall_in", 1, GEMM_SETA, 32'hBEEF, 0, 0, 1, 0, 0, 0, 0, 0,
                 32'h1000, 32'h2000, 32'h3000, 8, 4, 16};
    vecs[7]  = '{"done_idle", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,
                 32'h1000, 32'h2000, 32'h3000, 8, 4, 16};
    vecs[8]  = '{"illegal_flush", 1, 3'b111, 0, 0, 1, 0, 0, 0, 0, 0, 0,
                 32'h1000, 32'h2000, 32'h3000, 8, 4, 16};
    vecs[9]  = '{"setdim_k0", 1, GEMM_SETDIM, 32'h0000_0008, 32'h10, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 8, 0, 16};
    vecs[10] = '{"start_k0", 1, GEMM_START, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                 0, 0, 0, 8, 0, 16};
    vecs[11] = '{"illegal_flush_err", 1, 3'b111, 0, 0, 1, 0, 0, 0, 0, 0, 1,
                 0, 0, 0, 8, 0, 16};

    rst = 1'b1; is_gemm = 0; func3 = 0; rs1 = 0; rs2 = 0; flush = 0; stall_in = 0; done = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 32'(busy_o), 0);
    chk("rst start", 32'(gemm_start_o), 0);
    chk("rst err", 32'(err_o), 0);
    chk("rst perf", perf_cycles_o, 0);
    chk("rst base_a", base_a_o, 0);
    chk("rst dim_m", 32'(dim_m_o), 0);
    @(negedge clk);
    rst = 1'b0;

    run_rows(0, 9);

    // Run 1: 20-cycle run
    p0 = pulses;
    cyc(1, GEMM_START, 0, 0, 0, 0, 0, s);
    chk("r1 start stall", 32'(s), 0);
    chk("r1 pulse", 32'(gemm_start_o), 1);
    chk("r1 busy", 32'(busy_o), 1);
    chk("r1 perf clr", perf_cycles_o, 0);
    for (int i = 0; i < 19; i++) cyc(0, 0, 0, 0, 0, 0, 0, s);
    chk("r1 perf mid", perf_cycles_o, 19);
    chk("r1 busy mid", 32'(busy_o), 1);
    cyc(0, 0, 0, 0, 0, 0, 1, s);
    chk("r1 busy done", 32'(busy_o), 0);
    chk("r1 perf", perf_cycles_o, 20);
    chk("r1 pulse count", 32'(pulses - p0), 1);

    // Run 2: START held during RUN, done at cycle 15
    p0 = pulses;
    cyc(1, GEMM_START, 0, 0, 0, 0, 0, s);
    for (int i = 1; i <= 14; i++) begin
      cyc(1, GEMM_START, 0, 0, 0, 0, 0, s);
      chk($sformatf("r2 stall c%0d", i), 32'(s), 1);
    end
    cyc(1, GEMM_START, 0, 0, 0, 0, 1, s);
    chk("r2 stall done cyc", 32'(s), 1);
    chk("r2 busy done", 32'(busy_o), 0);
    chk("r2 perf", perf_cycles_o, 15);
    chk("r2 no early pulse", 32'(gemm_start_o), 0);
    cyc(1, GEMM_START, 0, 0, 0, 0, 0, s);
    chk("r2 stall fell", 32'(s), 0);
    chk("r2 second pulse", 32'(gemm_start_o), 1);
    chk("r2 busy again", 32'(busy_o), 1);

    // Run 3 (from second pulse): SETA held during RUN
    for (int i = 0; i < 5; i++) begin
      cyc(1, GEMM_SETA, 32'hDEAD, 0, 0, 0, 0, s);
      chk($sformatf("r3 seta stall %0d", i), 32'(s), 1);
    end
    chk("r3 one pulse each", 32'(pulses - p0), 2);
    cyc(1, GEMM_SETA, 32'hDEAD, 0, 0, 0, 1, s);
    chk("r3 stall done cyc", 32'(s), 1);
    chk("r3 base_a frozen", base_a_o, 32'h1000);
    chk("r3 perf", perf_cycles_o, 6);
    cyc(1, GEMM_SETA, 32'hDEAD, 0, 0, 0, 0, s);
    chk("r3 seta accepted", 32'(s), 0);
    chk("r3 base_a", base_a_o, 32'hDEAD);
    chk("r3 pulse count", 32'(pulses - p0), 2);

    // Run 4: done in the pulse cycle
    cyc(1, GEMM_START, 0, 0, 0, 0, 0, s);
    cyc(0, 0, 0, 0, 0, 0, 1, s);
    chk("r4 busy", 32'(busy_o), 0);
    chk("r4 perf", perf_cycles_o, 1);

    // Run 5: illegal func3 in RUN is not stalled and sets err
    cyc(1, GEMM_START, 0, 0, 0, 0, 0, s);
    cyc(1, 3'b110, 0, 0, 0, 0, 0, s);
    chk("r5 illegal stall", 32'(s), 0);
    chk("r5 err", 32'(err_o), 1);
    chk("r5 busy", 32'(busy_o), 1);
    cyc(0, 0, 0, 0, 0, 0, 1, s);
    chk("r5 perf", perf_cycles_o, 2);
    chk("r5 err sticky", 32'(err_o), 1);

    // stall_i held on START for 3 cycles
    p0 = pulses;
    for (int i = 0; i < 3; i++) begin
      cyc(1, GEMM_START, 0, 0, 0, 1, 0, s);
      chk($sformatf("stall_in start %0d", i), 32'(gemm_start_o), 0);
    end
    cyc(1, GEMM_START, 0, 0, 0, 0, 0, s);
    chk("stall_in release pulse", 32'(gemm_start_o), 1);
    cyc(0, 0, 0, 0, 0, 0, 0, s);
    cyc(0, 0, 0, 0, 0, 0, 0, s);
    chk("stall_in pulse count", 32'(pulses - p0), 1);
    chk("stall_in busy", 32'(busy_o), 1);

    // Reset mid-run
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst busy", 32'(busy_o), 0);
    chk("midrst err", 32'(err_o), 0);
    chk("midrst base_a", base_a_o, 0);
    chk("midrst base_b", base_b_o, 0);
    chk("midrst base_c", base_c_o, 0);
    chk("midrst dims", 32'({dim_m_o, dim_k_o, dim_n_o}), 0);
    chk("midrst perf", perf_cycles_o, 0);
    @(negedge clk);
    rst = 1'b0;

    run_rows(9, 12);

    cyc(0, 0, 0, 0, 0, 0, 0, s);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
